// File: rtl/udp_axis_32to8.sv
`default_nettype none
// ============================================================================
// udp_axis_32to8 : serialises 32-bit AXI-Stream words MSB-first onto an
//                  8-bit UDP byte stream. Optional length check: UDP_LEN_CHECK_EN.
// Revision       : 1.0
// ============================================================================
module udp_axis_32to8 (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] axis_tdata_in,
  input  logic        axis_tvalid_in,
  input  logic        axis_tfirst_in,
  input  logic [3:0]  axis_tkeep_in,
  input  logic        axis_tlast_in,
  output logic        axis_tready_out,
  input  logic [15:0] udp_length_in,
  output logic [7:0]  udp_axis_tdata_out,
  output logic        udp_axis_tvalid_out,
  output logic        udp_axis_tlast_out,
  input  logic        udp_axis_tready_in,
  output logic        pkt_done_out,
  output logic        len_err_out
);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_SEND = 1'b1
  } state_t;

  state_t      r_state, w_state_nxt;
  logic [31:0] r_word, w_word_nxt;
  logic [1:0]  r_idx, w_idx_nxt;
  logic [1:0]  r_last_idx, w_last_idx_nxt;
  logic        r_last, w_last_nxt;
  logic [7:0]  r_tdata, w_byte_nxt;
  logic        r_tlast;
  logic        r_pkt_done;
  logic [1:0]  w_keep_last_idx;
  logic        w_final_byte;
  logic        w_out_hs;
  logic        w_in_hs;

  // Partial keep is honoured only on a tlast beat; anything else is a full word.
  always_comb begin
    w_keep_last_idx = 2'd3;
    if (axis_tlast_in) begin
      case (axis_tkeep_in)
        4'b1110: w_keep_last_idx = 2'd2;
        4'b1100: w_keep_last_idx = 2'd1;
        4'b1000: w_keep_last_idx = 2'd0;
        default: w_keep_last_idx = 2'd3;
      endcase
    end
  end

  assign w_final_byte    = (r_state == S_SEND) && (r_idx == r_last_idx);
  assign w_out_hs        = (r_state == S_SEND) && udp_axis_tready_in;
  assign axis_tready_out = (r_state == S_IDLE) || (w_final_byte && udp_axis_tready_in);
  assign w_in_hs         = axis_tvalid_in && axis_tready_out;

  // A new word is only accepted when the holding register is free or being
  // drained this cycle, so loading always wins over advancing the index.
  always_comb begin
    w_state_nxt    = r_state;
    w_word_nxt     = r_word;
    w_idx_nxt      = r_idx;
    w_last_idx_nxt = r_last_idx;
    w_last_nxt     = r_last;
    if (w_in_hs) begin
      w_state_nxt    = S_SEND;
      w_word_nxt     = axis_tdata_in;
      w_idx_nxt      = 2'd0;
      w_last_idx_nxt = w_keep_last_idx;
      w_last_nxt     = axis_tlast_in;
    end else if (w_out_hs) begin
      if (w_final_byte) begin
        w_state_nxt = S_IDLE;
      end else begin
        w_idx_nxt = r_idx + 2'd1;
      end
    end
  end

  always_comb begin
    w_byte_nxt = 8'h00;
    if (w_state_nxt == S_SEND) begin
      case (w_idx_nxt)
        2'd0:    w_byte_nxt = w_word_nxt[31:24];
        2'd1:    w_byte_nxt = w_word_nxt[23:16];
        2'd2:    w_byte_nxt = w_word_nxt[15:8];
        default: w_byte_nxt = w_word_nxt[7:0];
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_word     <= 32'h0;
      r_idx      <= 2'd0;
      r_last_idx <= 2'd3;
      r_last     <= 1'b0;
      r_tdata    <= 8'h00;
      r_tlast    <= 1'b0;
      r_pkt_done <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_word     <= w_word_nxt;
      r_idx      <= w_idx_nxt;
      r_last_idx <= w_last_idx_nxt;
      r_last     <= w_last_nxt;
      r_tdata    <= w_byte_nxt;
      r_tlast    <= (w_state_nxt == S_SEND) && w_last_nxt && (w_idx_nxt == w_last_idx_nxt);
      r_pkt_done <= w_out_hs && r_tlast;
    end
  end

  assign udp_axis_tdata_out  = r_tdata;
  assign udp_axis_tvalid_out = (r_state == S_SEND);
  assign udp_axis_tlast_out  = r_tlast;
  assign pkt_done_out        = r_pkt_done;

`ifdef UDP_LEN_CHECK_EN
  logic [16:0] r_exp_len;
  logic [16:0] r_byte_cnt;
  logic [16:0] w_byte_cnt_inc;
  logic        r_pkt_open;
  logic        r_len_err;

  assign w_byte_cnt_inc = (r_byte_cnt == 17'h1FFFF) ? r_byte_cnt : (r_byte_cnt + 17'd1);

  // The tlast comparison includes the byte being handshaken this cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_exp_len  <= 17'd0;
      r_byte_cnt <= 17'd0;
      r_pkt_open <= 1'b0;
      r_len_err  <= 1'b0;
    end else begin
      r_len_err <= (w_out_hs && r_tlast && (w_byte_cnt_inc != r_exp_len)) ||
                   (w_in_hs && axis_tfirst_in && r_pkt_open);
      if (w_in_hs && axis_tfirst_in) begin
        r_exp_len  <= {1'b0, udp_length_in} + 17'd1;
        r_byte_cnt <= 17'd0;
      end else if (w_out_hs) begin
        r_byte_cnt <= w_byte_cnt_inc;
      end
      if (w_in_hs) begin
        r_pkt_open <= !axis_tlast_in;
      end
    end
  end

  assign len_err_out = r_len_err;
`else
  logic w_unused_len;
  assign w_unused_len = ^{udp_length_in, axis_tfirst_in};
  assign len_err_out  = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_udp_axis_32to8.sv
`default_nettype none
// tb_udp_axis_32to8 : table of directed packets plus hand-written reset and
// tfirst-restart sequences for udp_axis_32to8.
module tb_udp_axis_32to8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] axis_tdata_in = 32'h0;
  logic        axis_tvalid_in = 1'b0;
  logic        axis_tfirst_in = 1'b0;
  logic [3:0]  axis_tkeep_in = 4'h0;
  logic        axis_tlast_in = 1'b0;
  logic        axis_tready_out;
  logic [15:0] udp_length_in = 16'h0;
  logic [7:0]  udp_axis_tdata_out;
  logic        udp_axis_tvalid_out;
  logic        udp_axis_tlast_out;
  logic        udp_axis_tready_in = 1'b1;
  logic        pkt_done_out;
  logic        len_err_out;

  always #5 clk = ~clk;

  udp_axis_32to8 dut (
    .clk                 (clk),
    .reset               (reset),
    .axis_tdata_in       (axis_tdata_in),
    .axis_tvalid_in      (axis_tvalid_in),
    .axis_tfirst_in      (axis_tfirst_in),
    .axis_tkeep_in       (axis_tkeep_in),
    .axis_tlast_in       (axis_tlast_in),
    .axis_tready_out     (axis_tready_out),
    .udp_length_in       (udp_length_in),
    .udp_axis_tdata_out  (udp_axis_tdata_out),
    .udp_axis_tvalid_out (udp_axis_tvalid_out),
    .udp_axis_tlast_out  (udp_axis_tlast_out),
    .udp_axis_tready_in  (udp_axis_tready_in),
    .pkt_done_out        (pkt_done_out),
    .len_err_out         (len_err_out)
  );

  // Words, keeps and bytes are left-justified: item 0 sits in the top bits.
  typedef struct packed {
    int          nw;
    logic [95:0] w;
    logic [11:0] k;
    logic [2:0]  fm;
    logic [15:0] len;
    int          nb;
    logic [95:0] b;
    logic        bp;
    int          er;
    int          erd;
  } vec_t;

  vec_t vecs [8];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  bit mon_en  = 1'b0;
  bit bp_mode = 1'b0;
  logic [7:0] q_data[$];
  logic       q_last[$];
  int first_in, first_out, last_cyc, done_due;
  int done_cnt, done_late, err_cnt, err_done, rdy_cnt;
  bit stall_prev;
  logic [7:0] stall_data;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input int nw, input logic [95:0] w, input logic [11:0] k,
                              input logic [2:0] fm, input logic [15:0] len, input int nb,
                              input logic [95:0] b, input logic bp, input int er, input int erd);
    vec_t v;
    v.nw = nw; v.w = w; v.k = k; v.fm = fm; v.len = len;
    v.nb = nb; v.b = b; v.bp = bp; v.er = er; v.erd = erd;
    return v;
  endfunction

  task automatic clear_mon();
    q_data.delete();
    q_last.delete();
    first_in = -1; first_out = -1; last_cyc = -1; done_due = -1;
    done_cnt = 0; done_late = 0; err_cnt = 0; err_done = 0; rdy_cnt = 0;
    stall_prev = 1'b0;
    stall_data = 8'h00;
  endtask

  // Observation point is the falling edge, half a cycle away from the active edge.
  always @(negedge clk) begin
    if (!reset && mon_en) begin
      if (stall_prev) begin
        chk("hold_valid", 32'(udp_axis_tvalid_out), 32'd1);
        chk("hold_data", 32'(udp_axis_tdata_out), 32'(stall_data));
      end
      if (axis_tvalid_in && axis_tready_out && first_in < 0) first_in = cyc;
      if (udp_axis_tvalid_out && first_out < 0) first_out = cyc;
      if (udp_axis_tvalid_out && axis_tready_out) rdy_cnt++;
      if (udp_axis_tvalid_out && udp_axis_tready_in) begin
        q_data.push_back(udp_axis_tdata_out);
        q_last.push_back(udp_axis_tlast_out);
        last_cyc = cyc;
        if (udp_axis_tlast_out) done_due = cyc + 1;
      end
      if (pkt_done_out) begin
        done_cnt++;
        if (cyc != done_due) done_late++;
      end
      if (len_err_out) begin
        err_cnt++;
        if (pkt_done_out) err_done++;
      end
      stall_prev = udp_axis_tvalid_out && !udp_axis_tready_in;
      stall_data = udp_axis_tdata_out;
    end
    cyc++;
  end

  // Downstream ready: constant high, or the repeating 1,0,0,1 backpressure pattern.
  initial begin
    int ph;
    logic [3:0] pat;
    ph  = 0;
    pat = 4'b1001;
    forever begin
      @(posedge clk); #1;
      if (bp_mode) begin
        udp_axis_tready_in = pat[ph];
        ph = (ph + 1) % 4;
      end else begin
        udp_axis_tready_in = 1'b1;
        ph = 0;
      end
    end
  end

  task automatic drive_word(input logic [31:0] d, input logic [3:0] k, input logic f,
                            input logic l, input logic [15:0] len);
    bit hs;
    int t;
    hs = 1'b0;
    t  = 0;
    axis_tdata_in  = d;
    axis_tkeep_in  = k;
    axis_tfirst_in = f;
    axis_tlast_in  = l;
    udp_length_in  = len;
    axis_tvalid_in = 1'b1;
    while (!hs && t < 100) begin
      @(negedge clk);
      hs = axis_tvalid_in && axis_tready_out;
      @(posedge clk); #1;
      t++;
    end
    chk("drive_hs", 32'(hs), 32'd1);
    axis_tvalid_in = 1'b0;
    axis_tfirst_in = 1'b0;
    axis_tlast_in  = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input string nm);
    int t, tl_idx, tl_n, exp_er, exp_erd;
    clear_mon();
    bp_mode = v.bp;
    mon_en  = 1'b1;
    for (int i = 0; i < v.nw; i++)
      drive_word(v.w[95-32*i -: 32], v.k[11-4*i -: 4], v.fm[2-i], (i == v.nw - 1), v.len);
    t = 0;
    while (done_cnt == 0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    repeat (3) @(negedge clk);
    mon_en  = 1'b0;
    bp_mode = 1'b0;

    chk({nm, "_nbytes"}, q_data.size(), v.nb);
    for (int j = 0; j < v.nb; j++)
      chk($sformatf("%s_b%0d", nm, j), (j < q_data.size()) ? 32'(q_data[j]) : 32'hxxxxxxxx,
          32'(v.b[95-8*j -: 8]));
    tl_n = 0;
    tl_idx = -1;
    foreach (q_last[j]) if (q_last[j]) begin
      tl_n++;
      if (tl_idx < 0) tl_idx = j;
    end
    chk({nm, "_tlast_cnt"}, tl_n, 1);
    chk({nm, "_tlast_pos"}, tl_idx, v.nb - 1);
    chk({nm, "_done_cnt"}, done_cnt, 1);
    chk({nm, "_done_late"}, done_late, 0);
    chk({nm, "_latency"}, first_out - first_in, 1);
    if (!v.bp) chk({nm, "_no_bubble"}, last_cyc - first_out, v.nb - 1);
    chk({nm, "_in_ready_cnt"}, rdy_cnt, v.nw);
`ifdef UDP_LEN_CHECK_EN
    exp_er  = v.er;
    exp_erd = v.erd;
`else
    exp_er  = 0;
    exp_erd = 0;
`endif
    chk({nm, "_len_err"}, err_cnt, exp_er);
    chk({nm, "_len_err_w_done"}, err_done, exp_erd);
    @(posedge clk); #1;
  endtask

  initial begin
    int t;
    //            nw words                                  keeps    fm      len  nb bytes                                     bp er erd
    vecs[0] = mk(1, 96'hA1B2C3D4_00000000_00000000, 12'hF00, 3'b100, 16'd3, 4,  96'hA1B2C3D4_00000000_00000000, 0, 0, 0);
    vecs[1] = mk(3, 96'h01020304_05060708_090A0B0C, 12'hFFC, 3'b100, 16'd9, 10, 96'h01020304_05060708_090A0000, 0, 0, 0);
    vecs[2] = mk(2, 96'h11223344_55667788_00000000, 12'hFF0, 3'b100, 16'd7, 8,  96'h11223344_55667788_00000000, 1, 0, 0);
    vecs[3] = mk(2, 96'hDEADBEEF_CAFEF00D_00000000, 12'hFF0, 3'b100, 16'd6, 8,  96'hDEADBEEF_CAFEF00D_00000000, 0, 1, 1);
    vecs[4] = mk(2, 96'h12345678_9ABCDEF0_00000000, 12'hF80, 3'b100, 16'd4, 5,  96'h12345678_9A000000_00000000, 0, 0, 0);
    vecs[5] = mk(1, 96'h0F1E2D3C_00000000_00000000, 12'h500, 3'b100, 16'd3, 4,  96'h0F1E2D3C_00000000_00000000, 0, 0, 0);
    vecs[6] = mk(2, 96'hAABBCCDD_EEFF0011_00000000, 12'hEE0, 3'b100, 16'd6, 7,  96'hAABBCCDD_EEFF0000_00000000, 0, 0, 0);
    vecs[7] = mk(2, 96'h01020304_05060708_00000000, 12'hFF0, 3'b110, 16'd3, 8,  96'h01020304_05060708_00000000, 0, 1, 0);

    repeat (3) @(posedge clk); #1;
    chk("rst_tvalid", 32'(udp_axis_tvalid_out), 32'd0);
    chk("rst_tlast", 32'(udp_axis_tlast_out), 32'd0);
    chk("rst_tdata", 32'(udp_axis_tdata_out), 32'd0);
    chk("rst_done", 32'(pkt_done_out), 32'd0);
    chk("rst_len_err", 32'(len_err_out), 32'd0);
    chk("rst_in_ready", 32'(axis_tready_out), 32'd1);
    reset = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 8; i++) run_vec(vecs[i], $sformatf("v%0d", i));

    // Reset while byte index 2 of a word is on the output.
    clear_mon();
    mon_en = 1'b1;
    drive_word(32'h1A2B3C4D, 4'hF, 1'b1, 1'b1, 16'd3);
    t = 0;
    while (q_data.size() < 2 && t < 50) begin
      @(posedge clk); #2;
      t++;
    end
    chk("mid_byte2", 32'(udp_axis_tdata_out), 32'h3C);
    reset = 1'b1;
    #1;
    mon_en = 1'b0;
    chk("mid_rst_tvalid", 32'(udp_axis_tvalid_out), 32'd0);
    chk("mid_rst_tlast", 32'(udp_axis_tlast_out), 32'd0);
    chk("mid_rst_tdata", 32'(udp_axis_tdata_out), 32'd0);
    chk("mid_rst_done", 32'(pkt_done_out), 32'd0);
    chk("mid_rst_in_ready", 32'(axis_tready_out), 32'd1);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    run_vec(vecs[0], "after_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/udp_axis_32to8.md
# udp_axis_32to8

Egress-side width converter returning SRIO-domain packets to the UDP byte stream. Accepts 32-bit AXI-Stream beats carrying tfirst, tkeep and tlast, plus a packet length in SRIO encoding (actual bytes minus 1). Serialises each beat MSB-first onto an 8-bit AXI-Stream with correct tlast. Sits between the SRIO response path and the UDP transmit path.

## Interface
- No parameters. Widths are fixed: 32-bit in, 8-bit out, 16-bit length.
- clk  input  1  single clock for both sides.
- reset  input  1  asynchronous, active-high.
- axis_tdata_in  input  32  word; byte 0 on [31:24], byte 3 on [7:0].
- axis_tvalid_in  input  1  word valid.
- axis_tfirst_in  input  1  first word of packet.
- axis_tkeep_in  input  4  byte enables; bit 3 = [31:24].
- axis_tlast_in  input  1  last word of packet.
- axis_tready_out  output  1  word accepted when high together with tvalid.
- udp_length_in  input  16  packet length minus 1; sampled on the tfirst beat.
- udp_axis_tdata_out  output  8  byte.
- udp_axis_tvalid_out  output  1  byte valid.
- udp_axis_tlast_out  output  1  final byte of packet.
- udp_axis_tready_in  input  1  downstream ready.
- pkt_done_out  output  1  one-cycle pulse after the final byte handshake.
- len_err_out  output  1  one-cycle pulse on length mismatch; see Configuration.

## Operation
- Holding register stores the word, keep, last flag and byte index (0..3). FSM states:
  - IDLE: register empty.
  - SEND: bytes pending.
- IDLE -> SEND on input handshake.
- In SEND, the current byte is word[31-8*idx -: 8]. Index advances on each output handshake.
- Byte count of a word = number of set keep bits. Legal keep values:
  - 4'b1111 on any beat.
  - 4'b1110, 4'b1100, 4'b1000 on a tlast beat only.
- Any other keep value is treated as 4'b1111.
- On the handshake of the last counted byte:
  - If a new input word is valid, it is loaded in the same cycle and the FSM stays in SEND.
  - Otherwise the FSM returns to IDLE.
- axis_tready_out = (state==IDLE) | (state==SEND & last counted byte & udp_axis_tready_in).
- udp_axis_tlast_out = stored last flag & current byte is the last counted byte.
- tfirst latches udp_length_in + 1 into a 17-bit expected count. The byte counter is reset to 0 on that beat.
- The byte counter is 17 bits and saturates at 17'h1FFFF.
- pkt_done_out pulses in the cycle after the tlast byte handshake.

## Timing
- Reset values: udp_axis_tvalid_out=0, udp_axis_tlast_out=0, udp_axis_tdata_out=0, pkt_done_out=0, len_err_out=0, axis_tready_out=1. FSM goes to IDLE and the counters clear.
- Latency: the first byte is valid the cycle after the input handshake.
- Throughput: one byte per clock with no bubble across words while downstream is ready.
- A full word occupies 4 cycles; a tkeep=4'b1000 tail occupies 1 cycle.
- udp_axis_tvalid_out and udp_axis_tdata_out are registered and held stable while udp_axis_tready_in is low.
- Reset asserted mid-packet: all outputs drop to reset values asynchronously. The partial packet is discarded with no tlast. The next accepted word starts fresh.
- A tfirst arriving while a packet is open (no tlast seen) restarts the byte count and the expected length.

## Configuration
- UDP_LEN_CHECK_EN defined:
  - On the tlast byte handshake, the byte count including that byte is compared with the expected count.
  - On mismatch, len_err_out pulses in the same cycle as pkt_done_out.
  - A tfirst arriving while a packet is open also pulses len_err_out, one cycle after that input handshake.
- UDP_LEN_CHECK_EN not defined: len_err_out is tied to 0. The length register and byte counter are not built, and udp_length_in is ignored.

## Test plan
- Single word 0xA1B2C3D4, keep 4'b1111, first+last, length 3, ready held high:
  - Bytes A1, B2, C3, D4 on 4 consecutive cycles starting 1 cycle after the handshake.
  - tlast on D4; pkt_done 1 cycle later; len_err 0.
- Three back-to-back words, last keep 4'b1100, length 9:
  - 10 contiguous bytes with no bubble; tlast on byte 10.
  - axis_tready_out high only in the cycles with the final-byte handshake.
- Downstream backpressure: udp_axis_tready_in toggles 1,0,0,1 per cycle:
  - Data and valid are held unchanged through the stalls.
  - No byte is lost or duplicated.
  - axis_tready_out stays low until the last byte handshake.
- With UDP_LEN_CHECK_EN, send 8 bytes (2 full words) with length 6:
  - len_err_out pulses once, coincident with pkt_done.
- Same test with the macro undefined: len_err_out stays 0.
- Reset asserted at byte index 2 of a word:
  - tvalid drops immediately.
  - A new single-word packet after reset emits exactly 4 bytes with tlast.
- tkeep 4'b1000 on the last word of a 5-byte packet, length 4:
  - Exactly 5 bytes, tlast on byte 5, len_err 0.
